bfp_block_scheduler: RTL

Controller for the block-floating-point normalizer path (magnitude estimator, block peak/shift calculator, delay FIFO, output shifter).
- Frames the input stream into BLOCK_SIZE blocks and generates the calculator's last-sample strobe.
- Drives delay-FIFO push/pop and queues each block's shift so the exponent stays stable for the whole output block.
- Applies ready/valid backpressure end to end, and zero-pads and drains a partial final block on flush.

---
 rtl/bfp_pkg.sv | 23 ++
 rtl/bfp_exp_queue.sv | 70 +++++++
 rtl/bfp_block_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/bfp_pkg.sv
// Shared types and helpers for the block-floating-point scheduler.
package bfp_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE,
        FILL,
        STREAM,
        PAD,
        DRAIN
    } state_t;

    // Bit positions inside the sticky error vector.
    localparam int ERR_UNDERRUN = 0;
    localparam int ERR_OVERFLOW = 1;
    localparam int ERR_WIDTH    = 2;

    // Exponent width needed to shift a datapath word of the given width.
    function automatic int shift_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/bfp_exp_queue.sv
// Small synchronous FIFO holding per-block shift values until the matching
// output block starts popping from the delay line.
module bfp_exp_queue
    import bfp_pkg::*;
#(
    parameter int SHIFT_WIDTH = shift_width(16),
    parameter int DEPTH       = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enq,
    input  logic [SHIFT_WIDTH-1:0] i_data,
    input  logic                   i_deq,
    output logic [SHIFT_WIDTH-1:0] o_head,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [SHIFT_WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg;
    logic                   wr_en;
    logic                   rd_en;

    assign o_full  = (count_reg == CNT_FULL);
    assign o_empty = (count_reg == '0);
    assign rd_en   = i_deq & ~o_empty;
    // A full queue still accepts a new value when a slot frees up this cycle.
    assign wr_en   = i_enq & (~o_full | rd_en);
    assign o_head  = mem_reg[rd_ptr_reg];

    // Storage slots: write at the write pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[wr_ptr_reg] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/bfp_block_scheduler.sv
// Block framing, delay-line push/pop and per-block exponent sequencing for
// the block-floating-point normalizer, with end-to-end backpressure and a
// zero-padding flush of the final partial block.
module bfp_block_scheduler
    import bfp_pkg::*;
#(
    parameter int BLOCK_SIZE  = 256,
    parameter int SHIFT_WIDTH = shift_width(16),
    parameter int EXPQ_DEPTH  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic                   i_flush,
    input  logic                   i_s_valid,
    output logic                   o_s_ready,
    output logic                   o_calc_valid,
    output logic                   o_calc_last,
    output logic                   o_pad,
    input  logic [SHIFT_WIDTH-1:0] i_shift,
    input  logic                   i_shift_valid,
    output logic                   o_fifo_push,
    output logic                   o_fifo_pop,
    input  logic                   i_m_ready,
    output logic                   o_m_valid,
    output logic                   o_m_last,
    output logic [SHIFT_WIDTH-1:0] o_exponent,
    output logic                   o_busy,
    output logic [1:0]             o_err
);

    localparam int CNT_W      = $clog2(BLOCK_SIZE);
    localparam int TMO_CYCLES = 4 * BLOCK_SIZE;
    localparam int TMO_W      = $clog2(TMO_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       in_cnt_reg, in_cnt_next;
    logic [CNT_W-1:0]       out_cnt_reg, out_cnt_next;
    logic                   primed_reg, primed_next;
    logic [TMO_W-1:0]       tmo_cnt_reg, tmo_cnt_next;
    logic [SHIFT_WIDTH-1:0] exponent_reg;
    logic                   m_valid_reg, m_last_reg;
    logic [ERR_WIDTH-1:0]   err_reg, err_next;

    logic s_ready, accept, pad_cycle, drain_cycle, push, pop;
    logic in_last, out_last, exp_starved, tmo_expired;
    logic q_enq, q_deq, q_full, q_empty, q_overflow;
    logic [SHIFT_WIDTH-1:0] q_head;

    bfp_exp_queue #(
        .SHIFT_WIDTH (SHIFT_WIDTH),
        .DEPTH       (EXPQ_DEPTH)
    ) u_exp_queue (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_enq   (q_enq),
        .i_data  (i_shift),
        .i_deq   (q_deq),
        .o_head  (q_head),
        .o_full  (q_full),
        .o_empty (q_empty)
    );

    assign in_last  = (in_cnt_reg == CNT_LAST);
    assign out_last = (out_cnt_reg == CNT_LAST);

    // Handshake and advance qualifiers per state.
    always_comb begin
        s_ready     = 1'b0;
        pad_cycle   = 1'b0;
        drain_cycle = 1'b0;
        case (state_reg)
            FILL:    s_ready     = 1'b1;
            // Starting a new output block needs that block's exponent queued.
            STREAM:  s_ready     = i_m_ready & ((out_cnt_reg != '0) | ~q_empty);
            PAD:     pad_cycle   = i_m_ready;
            DRAIN:   drain_cycle = i_m_ready & ((out_cnt_reg != '0) | ~q_empty);
            default: ;
        endcase
    end

    assign accept = i_s_valid & s_ready;
    assign push   = accept | pad_cycle;
    // Padding after a FILL-only flush has nothing older in the delay line to pop.
    assign pop    = ((state_reg == STREAM) & accept)
                  | ((state_reg == PAD) & pad_cycle & primed_reg)
                  | drain_cycle;

    assign q_enq       = i_shift_valid;
    assign q_deq       = pop & (out_cnt_reg == '0);
    assign q_overflow  = q_enq & q_full & ~q_deq;
    assign exp_starved = (state_reg == DRAIN) & (out_cnt_reg == '0) & q_empty;
    assign tmo_expired = exp_starved & (tmo_cnt_reg == TMO_LAST);

    // Next-state, counter and sticky-error logic.
    always_comb begin
        state_next   = state_reg;
        in_cnt_next  = push ? in_cnt_reg + CNT_W'(1) : in_cnt_reg;
        out_cnt_next = pop ? out_cnt_reg + CNT_W'(1) : out_cnt_reg;
        tmo_cnt_next = exp_starved ? tmo_cnt_reg + TMO_W'(1) : '0;
        err_next     = err_reg;
        err_next[ERR_OVERFLOW] = err_reg[ERR_OVERFLOW] | q_overflow;
        err_next[ERR_UNDERRUN] = err_reg[ERR_UNDERRUN] | tmo_expired;
        case (state_reg)
            IDLE: begin
                if (i_enable) state_next = FILL;
            end
            FILL: begin
                if (i_flush) begin
                    if (in_cnt_next != '0) state_next = PAD;
                    else if (accept)       state_next = DRAIN;
                    else                   state_next = IDLE;
                end else if (accept && in_last) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (i_flush) state_next = (in_cnt_next != '0) ? PAD : DRAIN;
            end
            PAD: begin
                if (pad_cycle && in_last) state_next = DRAIN;
            end
            DRAIN: begin
                if ((drain_cycle && out_last) || tmo_expired) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (state_next == IDLE)        primed_next = 1'b0;
        else if (state_next == STREAM) primed_next = 1'b1;
        else                           primed_next = primed_reg;
    end

    // State, counters, exponent hold register and registered output strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= IDLE;
            in_cnt_reg   <= '0;
            out_cnt_reg  <= '0;
            primed_reg   <= 1'b0;
            tmo_cnt_reg  <= '0;
            exponent_reg <= '0;
            m_valid_reg  <= 1'b0;
            m_last_reg   <= 1'b0;
            err_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            in_cnt_reg  <= in_cnt_next;
            out_cnt_reg <= out_cnt_next;
            primed_reg  <= primed_next;
            tmo_cnt_reg <= tmo_cnt_next;
            err_reg     <= err_next;
            m_valid_reg <= pop;
            m_last_reg  <= pop & out_last;
            if (q_deq) exponent_reg <= q_head;
        end
    end

    assign o_s_ready    = s_ready;
    assign o_calc_valid = push;
    assign o_calc_last  = push & in_last;
    assign o_pad        = pad_cycle;
    assign o_fifo_push  = push;
    assign o_fifo_pop   = pop;
    assign o_m_valid    = m_valid_reg;
    assign o_m_last     = m_last_reg;
    assign o_exponent   = exponent_reg;
    assign o_busy       = (state_reg != IDLE);
    assign o_err        = err_reg;

endmodule
